// File: rtl/regfile_core.sv
// rtl/regfile_core.sv - RV32 register file with one-entry load scoreboard (optional REGFILE_BYPASS_EN)
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : same-cycle write-to-read forwarding (port A over port B), and
//               stall drops in the load-return cycle.
//   undefined : reads see stored contents only; stall holds through the
//               return cycle and drops on the following one.

module regfile_core #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            ld_issue,
    input  logic [4:0]      ld_rd,
    output logic            ld_ready,
    input  logic            ld_valid,
    input  logic [XLEN-1:0] ld_data,
    output logic            stall
);

    // Storage; entry 0 is never written and reads of x0 are forced to zero.
    logic [XLEN-1:0] regs [NREG];

    // Load scoreboard: one outstanding load and its destination.
    logic            pending;
    logic [4:0]      pend_rd;

    // Effective write strobes for the writeback port (A) and load return port (B).
    logic            wr_a;
    logic            wr_b;
    logic            rd_hit;

    assign wr_a     = wr_en && (wr_addr != 5'd0);
    assign wr_b     = ld_valid && pending && (pend_rd != 5'd0);

    // The slot frees in the return cycle, so a new load may issue back-to-back.
    assign ld_ready = !pending || ld_valid;

    // Register array update; port A is applied last so it wins on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_b) begin
                regs[pend_rd] <= ld_data;
            end
            if (wr_a) begin
                regs[wr_addr] <= wr_data;
            end
        end
    end

    // Scoreboard: accept an issue whenever the slot is free, else retire on return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            pend_rd <= 5'd0;
        end else if (ld_issue && ld_ready) begin
            pending <= 1'b1;
            pend_rd <= ld_rd;
        end else if (ld_valid && pending) begin
            pending <= 1'b0;
        end
    end

    // Operand 1 read, with optional same-cycle forwarding.
    always_comb begin
        rs1_data = regs[rs1_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_b && (pend_rd == rs1_addr)) begin
            rs1_data = ld_data;
        end
        if (wr_a && (wr_addr == rs1_addr)) begin
            rs1_data = wr_data;
        end
`endif
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end
    end

    // Operand 2 read, with optional same-cycle forwarding.
    always_comb begin
        rs2_data = regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_b && (pend_rd == rs2_addr)) begin
            rs2_data = ld_data;
        end
        if (wr_a && (wr_addr == rs2_addr)) begin
            rs2_data = wr_data;
        end
`endif
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end
    end

    // Hazard detect against the outstanding load destination (RAW on operands, WAW on writeback).
    always_comb begin
        rd_hit = (rs1_addr == pend_rd) || (rs2_addr == pend_rd) ||
                 (wr_en && (wr_addr == pend_rd));
`ifdef REGFILE_BYPASS_EN
        stall  = pending && (pend_rd != 5'd0) && !ld_valid && rd_hit;
`else
        stall  = pending && (pend_rd != 5'd0) && rd_hit;
`endif
    end

endmodule
